// File: rtl/cpu16_regfile_pkg.sv
// Shared types and helpers for the cpu16 multi-port register file.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu16_regfile_pkg;

  localparam int DATA_WIDTH      = 16;
  localparam int NUM_REGS        = 16;
  localparam int INDEX_WIDTH     = $clog2(NUM_REGS);
  // Upper bound on write ports that the priority select below can handle
  localparam int MAX_WRITE_PORTS = 8;
  localparam int WP_SEL_WIDTH    = $clog2(MAX_WRITE_PORTS);

  typedef logic [DATA_WIDTH-1:0]  word_t;
  typedef logic [INDEX_WIDTH-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  // Result of a write-port priority search: any hit, and which port won
  typedef struct packed {
    logic                    hit;
    logic [WP_SEL_WIDTH-1:0] port;
  } wp_sel_t;

  // Highest-numbered hitting port wins; shared by storage update and bypass
  function automatic wp_sel_t wp_select(input logic [MAX_WRITE_PORTS-1:0] hits);
    wp_sel_t sel;
    sel = '0;
    for (int i = 0; i < MAX_WRITE_PORTS; i++) begin
      if (hits[i]) begin
        sel.hit  = 1'b1;
        sel.port = WP_SEL_WIDTH'(i);
      end
    end
    return sel;
  endfunction

  // An index that names real, writable, trackable storage:
  // in range and not the hardwired zero register
  function automatic logic idx_live(input int idx, input int num_regs, input bit zero_reg);
    return (idx < num_regs) && !(zero_reg && (idx == int'(ZERO_REG)));
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bundle of read, write and reserve signals between issue/writeback and the register file.
// Latency: n/a (wires only).
// Backpressure: none; readBusy is the stall indication for the issue stage.
interface register_file_mp_if
  import cpu16_regfile_pkg::*;
#(
  parameter int DataWidth     = DATA_WIDTH,
  parameter int NumRegs       = NUM_REGS,
  parameter int IndexWidth    = $clog2(NumRegs),
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 2
);

  logic [NumWritePorts-1:0]                 writeEn;
  logic [NumWritePorts-1:0][IndexWidth-1:0] writeAddr;
  logic [NumWritePorts-1:0][DataWidth-1:0]  writeData;
  logic                                     reserveEn;
  logic [IndexWidth-1:0]                    reserveAddr;
  logic [NumReadPorts-1:0][IndexWidth-1:0]  readAddr;
  logic [NumReadPorts-1:0][DataWidth-1:0]   readData;
  logic [NumReadPorts-1:0]                  readBusy;
  logic                                     idle;

  modport master (
    output writeEn, writeAddr, writeData, reserveEn, reserveAddr, readAddr,
    input  readData, readBusy, idle
  );

  modport slave (
    input  writeEn, writeAddr, writeData, reserveEn, reserveAddr, readAddr,
    output readData, readBusy, idle
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, set by reserve, cleared by writeback.
// Latency: busy updates at the clock edge; readBusy/idle are combinational from the flops.
// Backpressure: none; readBusy tells the issue stage to stall on an unresolved operand.
module regfile_scoreboard
  import cpu16_regfile_pkg::*;
#(
  parameter int NumRegs       = NUM_REGS,
  parameter int IndexWidth    = $clog2(NumRegs),
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 2,
  parameter bit ZeroReg       = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  // Write enables arrive already filtered to live indices
  input  logic [NumWritePorts-1:0]                 wr_en_i,
  input  logic [NumWritePorts-1:0][IndexWidth-1:0] wr_addr_i,
  input  logic                                     rsv_en_i,
  input  logic [IndexWidth-1:0]                    rsv_addr_i,
  input  logic [NumReadPorts-1:0][IndexWidth-1:0]  rd_addr_i,
  // Per read port: a same-cycle write is being forwarded, so the operand is ready
  input  logic [NumReadPorts-1:0]                  byp_hit_i,
  output logic [NumReadPorts-1:0]                  rd_busy_o,
  output logic                                     idle_o
);

  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;

  // Writes clear first, then a reserve re-sets: the newer producer keeps the register pending
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NumWritePorts; i++) begin
      if (wr_en_i[i]) begin
        busy_d[wr_addr_i[i]] = 1'b0;
      end
    end
    if (rsv_en_i && idx_live(int'(rsv_addr_i), NumRegs, ZeroReg)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  // Busy flops, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Operand is busy unless it is the zero register, out of range, or being forwarded now
  always_comb begin
    rd_busy_o = '0;
    for (int j = 0; j < NumReadPorts; j++) begin
      if (idx_live(int'(rd_addr_i[j]), NumRegs, ZeroReg)) begin
        rd_busy_o[j] = busy_q[rd_addr_i[j]] & ~byp_hit_i[j];
      end
    end
  end

  assign idle_o = ~|busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with hardwired r0, write-to-read bypass and a busy scoreboard.
// Latency: reads combinational (zero cycle); writes and reserves take effect at the clock edge.
// Backpressure: none; issue stalls on readBusy, writeback is always accepted.
module register_file_mp
  import cpu16_regfile_pkg::*;
#(
  parameter int                   DataWidth     = DATA_WIDTH,
  parameter int                   NumRegs       = NUM_REGS,
  parameter int                   IndexWidth    = $clog2(NumRegs),
  parameter int                   NumReadPorts  = 2,
  parameter int                   NumWritePorts = 2,
  parameter bit                   Bypass        = 1'b1,
  parameter bit                   ZeroReg       = 1'b1,
  parameter logic [DataWidth-1:0] ResetValue    = '0
) (
  input  logic               clk,
  input  logic               rst,
  register_file_mp_if.slave  bus
);

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [DataWidth-1:0] regs_d [NumRegs];

  // Write strobes that actually land: in range and not aimed at the zero register
  logic [NumWritePorts-1:0]               wr_ok;
  logic [MAX_WRITE_PORTS-1:0]             wr_hits;
  wp_sel_t                                wr_sel;
  logic [MAX_WRITE_PORTS-1:0]             rd_hits;
  wp_sel_t                                rd_sel;
  logic [NumReadPorts-1:0][DataWidth-1:0] rd_data;
  logic [NumReadPorts-1:0]                byp_hit;

  // Qualify each write port against the live index range
  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < NumWritePorts; i++) begin
      wr_ok[i] = bus.writeEn[i] && idx_live(int'(bus.writeAddr[i]), NumRegs, ZeroReg);
    end
  end

  // Per register, take the data of the highest-numbered port writing it this cycle
  always_comb begin
    regs_d  = regs_q;
    wr_hits = '0;
    wr_sel  = '0;
    for (int r = 0; r < NumRegs; r++) begin
      wr_hits = '0;
      for (int i = 0; i < NumWritePorts; i++) begin
        wr_hits[i] = wr_ok[i] && (int'(bus.writeAddr[i]) == r);
      end
      wr_sel = wp_select(wr_hits);
      for (int i = 0; i < NumWritePorts; i++) begin
        if (wr_sel.hit && (int'(wr_sel.port) == i)) begin
          regs_d[r] = bus.writeData[i];
        end
      end
    end
  end

  // Register array, loaded with ResetValue asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NumRegs; r++) begin
        regs_q[r] <= ResetValue;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read mux: stored value, overridden by a same-cycle write when bypass is enabled;
  // r0 (with ZeroReg) and out-of-range indices read as zero
  always_comb begin
    rd_data = '0;
    byp_hit = '0;
    rd_hits = '0;
    rd_sel  = '0;
    for (int j = 0; j < NumReadPorts; j++) begin
      rd_hits = '0;
      rd_sel  = '0;
      if (idx_live(int'(bus.readAddr[j]), NumRegs, ZeroReg)) begin
        rd_data[j] = regs_q[bus.readAddr[j]];
        for (int i = 0; i < NumWritePorts; i++) begin
          rd_hits[i] = wr_ok[i] && (bus.writeAddr[i] == bus.readAddr[j]);
        end
        rd_sel = wp_select(rd_hits);
        if (Bypass && rd_sel.hit) begin
          byp_hit[j] = 1'b1;
          for (int i = 0; i < NumWritePorts; i++) begin
            if (int'(rd_sel.port) == i) begin
              rd_data[j] = bus.writeData[i];
            end
          end
        end
      end
    end
  end

  assign bus.readData = rd_data;

  regfile_scoreboard #(
    .NumRegs       (NumRegs),
    .IndexWidth    (IndexWidth),
    .NumReadPorts  (NumReadPorts),
    .NumWritePorts (NumWritePorts),
    .ZeroReg       (ZeroReg)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_ok),
    .wr_addr_i  (bus.writeAddr),
    .rsv_en_i   (bus.reserveEn),
    .rsv_addr_i (bus.reserveAddr),
    .rd_addr_i  (bus.readAddr),
    .byp_hit_i  (byp_hit),
    .rd_busy_o  (bus.readBusy),
    .idle_o     (bus.idle)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed vector table, Bypass=0 sequences, random vs model,
// and an asynchronous mid-cycle reset. A second instance with Bypass=0 shares the stimulus.
module tb_register_file_mp;
  import cpu16_regfile_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  register_file_mp_if rf_if ();
  register_file_mp_if nb_if ();

  assign nb_if.writeEn     = rf_if.writeEn;
  assign nb_if.writeAddr   = rf_if.writeAddr;
  assign nb_if.writeData   = rf_if.writeData;
  assign nb_if.reserveEn   = rf_if.reserveEn;
  assign nb_if.reserveAddr = rf_if.reserveAddr;
  assign nb_if.readAddr    = rf_if.readAddr;

  register_file_mp #(.Bypass(1'b1)) dut    (.clk(clk), .rst(rst), .bus(rf_if));
  register_file_mp #(.Bypass(1'b0)) dut_nb (.clk(clk), .rst(rst), .bus(nb_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural state only
  logic [15:0] m_mem [16];
  bit   [15:0] m_busy;

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_mem[r] = 16'h0000;
    m_busy = '0;
  endtask

  // Architectural effect of one clock edge, using the inputs held across it
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rf_if.writeEn[i] && rf_if.writeAddr[i] != 4'd0) begin
        m_mem[rf_if.writeAddr[i]]  = rf_if.writeData[i];
        m_busy[rf_if.writeAddr[i]] = 1'b0;
      end
    end
    if (rf_if.reserveEn && rf_if.reserveAddr != 4'd0) m_busy[rf_if.reserveAddr] = 1'b1;
  endtask

  function automatic logic [15:0] exp_data(input bit byp, input logic [3:0] a);
    logic [15:0] v;
    if (a == 4'd0) return 16'h0000;
    v = m_mem[a];
    if (byp) begin
      for (int i = 0; i < 2; i++)
        if (rf_if.writeEn[i] && rf_if.writeAddr[i] == a) v = rf_if.writeData[i];
    end
    return v;
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [3:0] a);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2; i++)
      if (rf_if.writeEn[i] && rf_if.writeAddr[i] == a) hit = 1'b1;
    return (a != 4'd0) && m_busy[a] && !(byp && hit);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_model(input string tag);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s.byp.d%0d", tag, j), 32'(rf_if.readData[j]), 32'(exp_data(1'b1, rf_if.readAddr[j])));
      check($sformatf("%s.byp.b%0d", tag, j), 32'(rf_if.readBusy[j]), 32'(exp_busy(1'b1, rf_if.readAddr[j])));
      check($sformatf("%s.nb.d%0d", tag, j), 32'(nb_if.readData[j]), 32'(exp_data(1'b0, rf_if.readAddr[j])));
      check($sformatf("%s.nb.b%0d", tag, j), 32'(nb_if.readBusy[j]), 32'(exp_busy(1'b0, rf_if.readAddr[j])));
    end
    check($sformatf("%s.byp.idle", tag), 32'(rf_if.idle), 32'(m_busy == '0));
    check($sformatf("%s.nb.idle", tag), 32'(nb_if.idle), 32'(m_busy == '0));
  endtask

  task automatic drive(input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                       input logic [15:0] wd0, input logic [15:0] wd1, input logic rsv,
                       input logic [3:0] ra, input logic [3:0] rd0, input logic [3:0] rd1);
    rf_if.writeEn      = we;
    rf_if.writeAddr[0] = wa0;
    rf_if.writeAddr[1] = wa1;
    rf_if.writeData[0] = wd0;
    rf_if.writeData[1] = wd1;
    rf_if.reserveEn    = rsv;
    rf_if.reserveAddr  = ra;
    rf_if.readAddr[0]  = rd0;
    rf_if.readAddr[1]  = rd1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [3:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic        rsv;
    logic [3:0]  ra, rd0, rd1;
    logic [15:0] ed0, ed1;
    logic [1:0]  ebusy;   // {port1, port0}
    logic        eidle;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                              input logic [15:0] wd0, input logic [15:0] wd1, input logic rsv,
                              input logic [3:0] ra, input logic [3:0] rd0, input logic [3:0] rd1,
                              input logic [15:0] ed0, input logic [15:0] ed1,
                              input logic [1:0] ebusy, input logic eidle);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.rsv = rsv; v.ra = ra; v.rd0 = rd0; v.rd1 = rd1;
    v.ed0 = ed0; v.ed1 = ed1; v.ebusy = ebusy; v.eidle = eidle;
    return v;
  endfunction

  initial begin
    logic [3:0] a0, a1, q0, q1;
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b0;
    drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd15);

    // Expected outputs are the values seen before the edge that commits each row
    //          we     wa0   wa1   wd0       wd1       rsv   ra    rd0   rd1   ed0       ed1       busy   idle
    vecs.push_back(mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd15, 16'h0000, 16'h0000, 2'b00, 1'b1));
    vecs.push_back(mk(2'b11, 4'd3, 4'd3, 16'hAAAA, 16'h5555, 1'b0, 4'd0, 4'd3, 4'd5,  16'h5555, 16'h0000, 2'b00, 1'b1));
    vecs.push_back(mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd0,  16'h5555, 16'h0000, 2'b00, 1'b1));
    vecs.push_back(mk(2'b01, 4'd7, 4'd0, 16'h1234, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd3,  16'h1234, 16'h5555, 2'b00, 1'b1));
    vecs.push_back(mk(2'b10, 4'd0, 4'd0, 16'h0000, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd7,  16'h0000, 16'h1234, 2'b00, 1'b1));
    vecs.push_back(mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd7,  16'h0000, 16'h1234, 2'b00, 1'b1));
    vecs.push_back(mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1, 4'd4, 4'd4, 4'd4,  16'h0000, 16'h0000, 2'b00, 1'b1));
    vecs.push_back(mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd3,  16'h0000, 16'h5555, 2'b01, 1'b0));
    vecs.push_back(mk(2'b01, 4'd4, 4'd0, 16'h00C3, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd4,  16'h00C3, 16'h00C3, 2'b00, 1'b0));
    vecs.push_back(mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd3,  16'h00C3, 16'h5555, 2'b00, 1'b1));
    vecs.push_back(mk(2'b10, 4'd0, 4'd4, 16'h0000, 16'h0011, 1'b1, 4'd4, 4'd4, 4'd4,  16'h0011, 16'h0011, 2'b00, 1'b1));
    vecs.push_back(mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd4,  16'h0011, 16'h0011, 2'b11, 1'b0));
    vecs.push_back(mk(2'b01, 4'd4, 4'd0, 16'h2222, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd0,  16'h2222, 16'h0000, 2'b00, 1'b0));
    vecs.push_back(mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd0,  16'h2222, 16'h0000, 2'b00, 1'b1));
    vecs.push_back(mk(2'b11, 4'd8, 4'd9, 16'h1111, 16'h2222, 1'b0, 4'd0, 4'd8, 4'd9,  16'h1111, 16'h2222, 2'b00, 1'b1));

    // Reset state, observed while reset is held
    #1 rst = 1'b1;
    #2;
    check("reset.d0", 32'(rf_if.readData[0]), 32'h0);
    check("reset.d1", 32'(rf_if.readData[1]), 32'h0);
    check("reset.busy", 32'(rf_if.readBusy), 32'h0);
    check("reset.idle", 32'(rf_if.idle), 32'h1);
    check("reset.nb.idle", 32'(nb_if.idle), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Directed table
    foreach (vecs[k]) begin
      drive(vecs[k].we, vecs[k].wa0, vecs[k].wa1, vecs[k].wd0, vecs[k].wd1,
            vecs[k].rsv, vecs[k].ra, vecs[k].rd0, vecs[k].rd1);
      @(negedge clk);
      check($sformatf("vec%0d.d0", k), 32'(rf_if.readData[0]), 32'(vecs[k].ed0));
      check($sformatf("vec%0d.d1", k), 32'(rf_if.readData[1]), 32'(vecs[k].ed1));
      check($sformatf("vec%0d.b0", k), 32'(rf_if.readBusy[0]), 32'(vecs[k].ebusy[0]));
      check($sformatf("vec%0d.b1", k), 32'(rf_if.readBusy[1]), 32'(vecs[k].ebusy[1]));
      check($sformatf("vec%0d.idle", k), 32'(rf_if.idle), 32'(vecs[k].eidle));
      tick();
    end

    // Without bypass, a same-cycle write is invisible until after the edge (r7 holds 1234)
    drive(2'b01, 4'd7, 4'd0, 16'hABCD, 16'h0, 1'b0, 4'd0, 4'd7, 4'd7);
    @(negedge clk);
    check("nobyp.byp.d0", 32'(rf_if.readData[0]), 32'hABCD);
    check("nobyp.old.d0", 32'(nb_if.readData[0]), 32'h1234);
    tick();
    drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd7);
    @(negedge clk);
    check("nobyp.new.d0", 32'(nb_if.readData[0]), 32'hABCD);
    tick();
    drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 4'd6, 4'd6, 4'd6);
    @(negedge clk);
    tick();
    drive(2'b01, 4'd6, 4'd0, 16'h0066, 16'h0, 1'b0, 4'd0, 4'd6, 4'd6);
    @(negedge clk);
    check("nobyp.byp.b0", 32'(rf_if.readBusy[0]), 32'h0);
    check("nobyp.nb.b0", 32'(nb_if.readBusy[0]), 32'h1);
    check("nobyp.nb.d0", 32'(nb_if.readData[0]), 32'h0);
    check("nobyp.nb.idle", 32'(nb_if.idle), 32'h0);
    tick();
    drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd6, 4'd6);
    @(negedge clk);
    check("nobyp.after.d0", 32'(nb_if.readData[0]), 32'h0066);
    check("nobyp.after.b0", 32'(nb_if.readBusy[0]), 32'h0);
    check("nobyp.after.idle", 32'(nb_if.idle), 32'h1);
    tick();

    // Random traffic against the reference model, biased toward address collisions
    for (int c = 0; c < 400; c++) begin
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      q0 = ($urandom_range(0, 1) == 0) ? a0 : 4'($urandom_range(0, 15));
      q1 = ($urandom_range(0, 1) == 0) ? a1 : 4'($urandom_range(0, 15));
      drive(2'($urandom_range(0, 3)), a0, a1, 16'($urandom), 16'($urandom),
            ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), q0, q1);
      @(negedge clk);
      check_model($sformatf("rand%0d", c));
      tick();
    end

    // Asynchronous reset between edges with r9 busy and holding BEEF
    drive(2'b01, 4'd9, 4'd0, 16'hBEEF, 16'h0, 1'b0, 4'd0, 4'd9, 4'd9);
    @(negedge clk);
    tick();
    drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 4'd9, 4'd9, 4'd9);
    @(negedge clk);
    tick();
    drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd9, 4'd9);
    #1;
    check("arst.pre.d0", 32'(rf_if.readData[0]), 32'hBEEF);
    check("arst.pre.b0", 32'(rf_if.readBusy[0]), 32'h1);
    check("arst.pre.idle", 32'(rf_if.idle), 32'h0);
    rst = 1'b1;
    #1;
    check("arst.d0", 32'(rf_if.readData[0]), 32'h0);
    check("arst.b0", 32'(rf_if.readBusy[0]), 32'h0);
    check("arst.idle", 32'(rf_if.idle), 32'h1);
    check("arst.nb.d0", 32'(nb_if.readData[0]), 32'h0);
    check("arst.nb.idle", 32'(nb_if.idle), 32'h1);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_model("arst.post");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
